dcache_ctrl: RTL and testbench



---
 rtl/dcache_ctrl_pkg.sv | 34 +++
 rtl/dcache_ctrl_line_array.sv | 54 +++++
 rtl/dcache_ctrl.sv | 154 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared constants and types for the direct-mapped write-back data cache.
// Covers FSM encodings, line geometry and the line-array write request.
package dcache_ctrl_pkg;

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] WB_REQ      = 2'd1;
    localparam logic [1:0] REFILL_REQ  = 2'd2;
    localparam logic [1:0] REFILL_WAIT = 2'd3;

    localparam int LINE_WORDS = 4;
    localparam int OFFSET_W   = 4;
    localparam int LINE_BYTES = LINE_WORDS * 4;
    localparam int LINE_BITS  = LINE_BYTES * 8;

    typedef struct packed {
        logic                  fill;
        logic [LINE_BYTES-1:0] be;
        logic [LINE_BITS-1:0]  data;
    } line_wr_t;

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int awidth, input int lines);
        return awidth - OFFSET_W - $clog2(lines);
    endfunction

    // Place a 4-bit word mask at its word slot within the line.
    function automatic logic [LINE_BYTES-1:0] word_be(input logic [1:0] ws, input logic [3:0] we);
        return LINE_BYTES'(we) << {ws, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_ctrl_line_array.sv
// Tag/valid/dirty/data storage: combinational read port, one write port
// that either refills a whole line (clean) or merges bytes into it (dirty).
module dcache_line_array
    import dcache_ctrl_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = 6,
    parameter int TAG_W = 22
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [TAG_W-1:0]     wr_tag,
    input  line_wr_t             wr
);

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [LINE_BITS-1:0] data_q [LINES];

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= ~wr.fill;
        end
    end

    // Payload storage is deliberately left unreset; valid bits gate it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr.fill)
                tag_q[wr_idx] <= wr_tag;
            for (int b = 0; b < LINE_BYTES; b++)
                if (wr.be[b])
                    data_q[wr_idx][8*b +: 8] <= wr.data[8*b +: 8];
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Blocking direct-mapped write-back/write-allocate dcache controller.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int LINES  = 64,
    parameter int AWIDTH = 32,
    parameter int LWIDTH = 128
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AWIDTH-1:0]          dcache_addr,
    input  logic                       dcache_re,
    input  logic [3:0]                 dcache_we,
    input  logic [31:0]                dcache_din,
    output logic [31:0]                dcache_dout,
    output logic                       stall,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_rw,
    output logic [AWIDTH-OFFSET_W-1:0] mem_req_addr,
    output logic                       mem_req_data_valid,
    input  logic                       mem_req_data_ready,
    output logic [LWIDTH-1:0]          mem_req_data,
    input  logic                       mem_resp_valid,
    input  logic [LWIDTH-1:0]          mem_resp_data
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]                hit_count,
    output logic [31:0]                miss_count
`endif
);

    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(AWIDTH, LINES);

    logic [1:0]           state;
    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic [1:0]           wsel;
    logic                 request, hit, lookup_hit;
    logic                 line_valid, line_dirty;
    logic [TAG_W-1:0]     line_tag;
    logic [LINE_BITS-1:0] line_data;
    logic                 wr_en;
    line_wr_t             wr;
    logic                 cmd_left, data_left;
    logic                 unused_addr;

    assign idx         = dcache_addr[OFFSET_W +: IDX_W];
    assign tag         = dcache_addr[AWIDTH-1 -: TAG_W];
    assign wsel        = dcache_addr[3:2];
    assign unused_addr = ^dcache_addr[1:0];

    assign request    = dcache_re | (|dcache_we);
    assign hit        = line_valid & (line_tag == tag);
    assign lookup_hit = (state == IDLE) & request & hit;
    assign stall      = (state != IDLE) | (request & ~hit);

    // The same write port serves store hits and refills; refill wins by state.
    assign wr_en   = (lookup_hit & (|dcache_we)) | ((state == REFILL_WAIT) & mem_resp_valid);
    assign wr.fill = (state == REFILL_WAIT);
    assign wr.be   = wr.fill ? '1 : word_be(wsel, dcache_we);
    assign wr.data = wr.fill ? LINE_BITS'(mem_resp_data) : {LINE_WORDS{dcache_din}};

    dcache_line_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx),
        .rd_valid (line_valid),
        .rd_dirty (line_dirty),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (wr_en),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr       (wr)
    );

    // The core holds the address during a miss, so the victim is re-read live.
    assign mem_req_rw   = (state == WB_REQ);
    assign mem_req_addr = mem_req_rw ? {line_tag, idx} : {tag, idx};
    assign mem_req_data = LWIDTH'(line_data);

    assign cmd_left  = mem_req_valid & ~mem_req_ready;
    assign data_left = mem_req_data_valid & ~mem_req_data_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            mem_req_valid      <= 1'b0;
            mem_req_data_valid <= 1'b0;
            dcache_dout        <= '0;
        end else begin
            case (state)
                IDLE: if (request) begin
                    if (hit) begin
                        if (dcache_re)
                            dcache_dout <= line_data[32*wsel +: 32];
                    end else begin
                        mem_req_valid <= 1'b1;
                        if (line_valid & line_dirty) begin
                            state              <= WB_REQ;
                            mem_req_data_valid <= 1'b1;
                        end else begin
                            state <= REFILL_REQ;
                        end
                    end
                end
                WB_REQ: begin
                    mem_req_data_valid <= data_left;
                    if (!cmd_left && !data_left) begin
                        state         <= REFILL_REQ;
                        mem_req_valid <= 1'b1;
                    end else begin
                        mem_req_valid <= cmd_left;
                    end
                end
                REFILL_REQ: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    state         <= REFILL_WAIT;
                end
                REFILL_WAIT: if (mem_resp_valid)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // relookup marks the held request's post-refill hit so it is not counted.
    logic relookup;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            relookup   <= 1'b0;
        end else if ((state == REFILL_WAIT) && mem_resp_valid) begin
            relookup <= 1'b1;
        end else if ((state == IDLE) && request) begin
            relookup <= 1'b0;
            if (!relookup) begin
                if (hit) hit_count  <= hit_count + 32'd1;
                else     miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized scoreboard bench for dcache_ctrl against a flat-memory reference
// model plus a per-index residency model; memory side is a behavioural responder.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  dcache_addr;
    logic         dcache_re;
    logic [3:0]   dcache_we;
    logic [31:0]  dcache_din;
    logic [31:0]  dcache_dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic         mem_req_data_valid;
    logic         mem_req_data_ready;
    logic [127:0] mem_req_data;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .dcache_addr        (dcache_addr),
        .dcache_re          (dcache_re),
        .dcache_we          (dcache_we),
        .dcache_din         (dcache_din),
        .dcache_dout        (dcache_dout),
        .stall              (stall),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data       (mem_req_data),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count          (hit_count),
        .miss_count         (miss_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what memory holds from the core's point of view,
    // which line each index holds, and the backing memory's line contents.
    logic [31:0]  ref_mem   [logic [29:0]];
    logic [127:0] mem_lines [logic [27:0]];
    logic         ref_v [64];
    logic         ref_d [64];
    logic [21:0]  ref_t [64];
    logic [31:0]  exp_dout [$];
    logic [27:0]  exp_rd   [$];
    logic [27:0]  exp_wb   [$];
    int           exp_hit = 0, exp_miss = 0;

    bit hold_ready = 0, hold_resp = 0, rd_pending = 0;
    int order_mode = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic abort_run(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return (32'(wa) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [29:0] wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [127:0] ref_line(input logic [27:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[32*w +: 32] = ref_rd({la, 2'(w)});
        return l;
    endfunction

    function automatic logic [127:0] get_line(input logic [27:0] la);
        logic [127:0] l;
        if (mem_lines.exists(la)) return mem_lines[la];
        for (int w = 0; w < 4; w++) l[32*w +: 32] = init_word({la, 2'(w)});
        return l;
    endfunction

    // Apply one core request to the reference model and queue expectations.
    task automatic predict(input logic [31:0] a, input logic r, input logic [3:0] w,
                           input logic [31:0] d, output bit hit);
        logic [5:0]  ix = a[9:4];
        logic [21:0] tg = a[31:10];
        logic [31:0] wd;
        hit = ref_v[ix] && (ref_t[ix] == tg);
        if (!hit) begin
            if (ref_v[ix] && ref_d[ix]) exp_wb.push_back({ref_t[ix], ix});
            exp_rd.push_back(a[31:4]);
            ref_v[ix] = 1'b1; ref_t[ix] = tg; ref_d[ix] = 1'b0;
            exp_miss++;
        end else begin
            exp_hit++;
        end
        if (r) exp_dout.push_back(ref_rd(a[31:2]));
        if (w != 4'd0) begin
            wd = ref_rd(a[31:2]);
            for (int b = 0; b < 4; b++) if (w[b]) wd[8*b +: 8] = d[8*b +: 8];
            ref_mem[a[31:2]] = wd;
            ref_d[ix] = 1'b1;
        end
    endtask

    task automatic reset_model();
        logic [127:0] l;
        for (int i = 0; i < 64; i++) begin ref_v[i] = 1'b0; ref_d[i] = 1'b0; end
        exp_dout.delete(); exp_rd.delete(); exp_wb.delete();
        ref_mem.delete();
        foreach (mem_lines[la]) begin
            l = mem_lines[la];
            for (int w = 0; w < 4; w++) ref_mem[{la, 2'(w)}] = l[32*w +: 32];
        end
        exp_hit = 0; exp_miss = 0;
    endtask

    task automatic do_op(input logic [31:0] a, input logic r, input logic [3:0] w,
                         input logic [31:0] d, input bit hold);
        bit hit, ok;
        int n;
        logic [27:0] ha;
        @(negedge clk);
        dcache_addr = a; dcache_re = r; dcache_we = w; dcache_din = d;
        #1;
        predict(a, r, w, d, hit);
        chk("stall_issue", stall, !hit);
        if (hold) begin
            n = 0;
            while (!(mem_req_valid && !mem_req_rw) && n < 100) begin @(posedge clk); #1; n++; end
            if (!(mem_req_valid && !mem_req_rw)) abort_run("hold_wait");
            ha = mem_req_addr;
            ok = 1;
            repeat (10) begin
                @(negedge clk); #1;
                ok &= mem_req_valid && !mem_req_rw && (mem_req_addr == ha) && stall;
            end
            chk("hold_stable", ok, 1'b1);
            hold_ready = 0;
        end
        n = 0;
        while (stall !== 1'b0 && n < 500) begin @(negedge clk); #1; n++; end
        if (stall !== 1'b0) abort_run("op_timeout");
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) begin
            @(negedge clk);
            dcache_re = 1'b0; dcache_we = 4'd0;
        end
    endtask

    // Monitor: an accepted read must produce the queued word next cycle;
    // otherwise dout must hold its value.
    initial begin
        bit acc, rs;
        logic [31:0] prev = '0;
        forever begin
            @(negedge clk); #4;
            acc = dcache_re && !stall && !reset;
            rs  = reset;
            @(posedge clk); #1;
            if (acc) begin
                if (exp_dout.size() == 0) chk("dout_unexpected", dcache_dout, prev);
                else chk("dout", dcache_dout, exp_dout.pop_front());
            end else if (!rs) begin
                chk("dout_hold", dcache_dout, prev);
            end
            prev = dcache_dout;
        end
    end

    // Memory responder: random readiness, ordered/held modes, refill replies,
    // and occasional stray response pulses that the cache must ignore.
    initial begin
        bit wb_cmd = 0, wb_dat = 0;
        logic [27:0]  wb_a = '0, rd_a = '0;
        logic [127:0] wb_d = '0;
        int delay = 0;
        mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (reset) begin
                wb_cmd = 0; wb_dat = 0; rd_pending = 0;
                mem_req_ready = 0; mem_req_data_ready = 0;
                continue;
            end
            if (rd_pending) begin
                if (delay > 0) delay--;
                else if (!hold_resp) begin
                    mem_resp_valid = 1'b1; mem_resp_data = get_line(rd_a); rd_pending = 0;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
            end
            mem_req_ready      = ($urandom_range(0, 2) != 0);
            mem_req_data_ready = ($urandom_range(0, 2) != 0);
            if (hold_ready && !mem_req_rw) mem_req_ready = 1'b0;
            if (order_mode == 1 && mem_req_valid && mem_req_rw) mem_req_data_ready = 1'b0;
            if (order_mode == 2 && mem_req_data_valid) mem_req_ready = 1'b0;
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_rw) begin
                    wb_cmd = 1; wb_a = mem_req_addr;
                end else begin
                    chk("refill_after_wb", wb_cmd | wb_dat, 1'b0);
                    if (exp_rd.size() == 0) chk("refill_unexpected", mem_req_addr, 28'h0);
                    else chk("refill_addr", mem_req_addr, exp_rd.pop_front());
                    rd_pending = 1; rd_a = mem_req_addr; delay = $urandom_range(0, 3);
                end
            end
            if (mem_req_data_valid && mem_req_data_ready) begin
                wb_dat = 1; wb_d = mem_req_data;
            end
            if (wb_cmd && wb_dat) begin
                if (exp_wb.size() == 0) chk("wb_unexpected", wb_a, 28'h0);
                else chk("wb_addr", wb_a, exp_wb.pop_front());
                chk("wb_data", wb_d, ref_line(wb_a));
                mem_lines[wb_a] = wb_d;
                wb_cmd = 0; wb_dat = 0;
            end
        end
    end

    initial begin
        int n;
        bit hit;
        logic [31:0] a;
        reset = 1'b1;
        dcache_addr = '0; dcache_re = 0; dcache_we = '0; dcache_din = '0;
        mem_lines[28'h1000001] = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        reset_model();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_data_valid", mem_req_data_valid, 1'b0);
        chk("rst_dout", dcache_dout, 32'h0);

        // Cold miss then hit on the same line.
        do_op(32'h1000_0010, 1, 4'h0, 0, 0);
        do_op(32'h1000_0014, 1, 4'h0, 0, 0);
        // Partial store merge and read-with-write returning the old word.
        do_op(32'h1000_0018, 0, 4'hF, 32'h11223344, 0);
        do_op(32'h1000_0018, 0, 4'b0010, 32'h0000_5500, 0);
        do_op(32'h1000_0018, 1, 4'h0, 0, 0);
        do_op(32'h1000_001C, 1, 4'b0001, 32'h0000_00EE, 0);
        do_op(32'h1000_001C, 1, 4'h0, 0, 0);
        // Dirty victim at index 1, command-first then data-first acceptance.
        order_mode = 1;
        do_op(32'h2000_0010, 1, 4'h0, 0, 0);
        do_op(32'h2000_0014, 0, 4'b1100, 32'hCAFE_0000, 0);
        order_mode = 2;
        do_op(32'h1000_0018, 1, 4'h0, 0, 0);
        do_op(32'h2000_0014, 1, 4'h0, 0, 0);
        order_mode = 0;
        // Refill command held off for 10 cycles.
        hold_ready = 1;
        do_op(32'h3000_0040, 1, 4'h0, 0, 1);
        idle_cycles(2);

        // Reset while a refill is outstanding.
        hold_resp = 1;
        @(negedge clk);
        dcache_addr = 32'h4000_0050; dcache_re = 1; dcache_we = 0;
        predict(32'h4000_0050, 1, 4'h0, 0, hit);
        n = 0;
        while (!rd_pending && n < 100) begin @(posedge clk); #1; n++; end
        if (!rd_pending) abort_run("refill_wait");
        @(negedge clk); #2;
        reset = 1'b1;
        dcache_re = 0;
        #1;
        chk("midrst_stall", stall, 1'b0);
        chk("midrst_req_valid", mem_req_valid, 1'b0);
        chk("midrst_dout", dcache_dout, 32'h0);
`ifdef DCACHE_STATS_EN
        chk("midrst_hits", hit_count, 32'h0);
`endif
        hold_resp = 0;
        reset_model();
        @(negedge clk);
        @(negedge clk); #2;
        reset = 1'b0;
        do_op(32'h1000_0014, 1, 4'h0, 0, 0);

        // Random traffic over a few conflicting tags and indices.
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [3:0] w;
            order_mode = $urandom_range(0, 2);
            a = {22'h040000 + 22'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'b00};
            r = $urandom_range(0, 9);
            w = 4'($urandom_range(1, 15));
            if (r < 4)      do_op(a, 1, 4'h0, $urandom, 0);
            else if (r < 8) do_op(a, 0, w, $urandom, 0);
            else            do_op(a, 1, w, $urandom, 0);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(3);
        chk("wb_queue_drained", 32'(exp_wb.size()), 32'd0);
        chk("dout_queue_drained", 32'(exp_dout.size()), 32'd0);
`ifdef DCACHE_STATS_EN
        chk("hit_count", hit_count, 32'(exp_hit));
        chk("miss_count", miss_count, 32'(exp_miss));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        abort_run("global_timeout");
    end

endmodule
